ubtb_assoc: RTL

Parametrised set-associative micro-BTB for the fetch stage, succeeding the direct-mapped uBTB. It adds configurable sets, ways and partial-tag width, per-entry saturating confidence counters, round-robin replacement, a registered one-cycle lookup with a valid qualifier, and a synchronous flush. It sits beside the PC generator. It is looked up with the fetch PC and updated from branch resolution in the backend.

---
 rtl/ubtb_assoc_if.sv | 35 +++
 rtl/ubtb_assoc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ubtb_assoc_if.sv
// ubtb_assoc_if: lookup, resolution-update and flush signals of the
// set-associative micro-BTB. The fetch/backend side is the master.
interface ubtb_assoc_if;
   logic        pred_req;
   logic [31:0] pred_pc;
   logic        pred_valid;
   logic        pred_hit;
   logic        pred_taken;
   logic [31:0] pred_next_pc;
   logic [1:0]  pred_cut_pos;
   logic [1:0]  pred_branch_type;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;
   logic [31:0] update_target;
   logic [1:0]  update_cut_pos;
   logic [1:0]  update_branch_type;
   logic        flush;

   modport master (
      output pred_req, pred_pc,
      output update_valid, update_pc, update_taken, update_target,
      output update_cut_pos, update_branch_type, flush,
      input  pred_valid, pred_hit, pred_taken, pred_next_pc,
      input  pred_cut_pos, pred_branch_type
   );

   modport slave (
      input  pred_req, pred_pc,
      input  update_valid, update_pc, update_taken, update_target,
      input  update_cut_pos, update_branch_type, flush,
      output pred_valid, pred_hit, pred_taken, pred_next_pc,
      output pred_cut_pos, pred_branch_type
   );
endinterface

// File: rtl/ubtb_assoc.sv
// ubtb_assoc: set-associative micro-BTB with partial tags, saturating
// confidence counters, round-robin victim selection per set, a registered
// one-cycle lookup and a synchronous flush.
module ubtb_assoc #(
   parameter int unsigned SETS   = 16,
   parameter int unsigned WAYS   = 4,
   parameter int unsigned TAG_W  = 12,
   parameter int unsigned CONF_W = 2
) (
   input logic       clk,
   input logic       rst_n,
   ubtb_assoc_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [1:0]        BRANCH_TYPE_DIRECT = 2'd0;
   localparam logic [CONF_W-1:0] CONF_INIT = {1'b1, {(CONF_W-1){1'b0}}};
   localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(WAYS - 1);

   // entry storage
   logic              ent_valid  [SETS][WAYS];
   logic [TAG_W-1:0]  ent_tag    [SETS][WAYS];
   logic [31:0]       ent_target [SETS][WAYS];
   logic [1:0]        ent_cut    [SETS][WAYS];
   logic [1:0]        ent_type   [SETS][WAYS];
   logic [CONF_W-1:0] ent_conf   [SETS][WAYS];
   logic [WAY_W-1:0]  victim     [SETS];

   // address decode
   logic [IDX_W-1:0] u_idx, l_idx;
   logic [TAG_W-1:0] u_tag, l_tag;
   logic             unused_upd_pc;

   assign u_idx = bus.update_pc[IDX_W+1:2];
   assign u_tag = bus.update_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign l_idx = bus.pred_pc[IDX_W+1:2];
   assign l_tag = bus.pred_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign unused_upd_pc = ^bus.update_pc;

   // update decision: one entry write per cycle plus optional victim advance
   logic              u_hit, u_free, vic_inc, wr_en, wr_valid;
   logic [WAY_W-1:0]  u_hit_way, u_free_way, wr_way, vic_nxt;
   logic [TAG_W-1:0]  wr_tag;
   logic [31:0]       wr_target;
   logic [1:0]        wr_cut, wr_type;
   logic [CONF_W-1:0] wr_conf, cur_conf;

   // Resolve the update against the stored set and build the write record.
   always_comb begin
      u_hit      = 1'b0;
      u_hit_way  = '0;
      u_free     = 1'b0;
      u_free_way = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!u_hit && ent_valid[u_idx][w] && (ent_tag[u_idx][w] == u_tag)) begin
            u_hit     = 1'b1;
            u_hit_way = WAY_W'(w);
         end
         if (!u_free && !ent_valid[u_idx][w]) begin
            u_free     = 1'b1;
            u_free_way = WAY_W'(w);
         end
      end
      cur_conf  = ent_conf[u_idx][u_hit_way];
      wr_en     = 1'b0;
      wr_way    = u_hit_way;
      wr_valid  = 1'b0;
      wr_tag    = u_tag;
      wr_target = ent_target[u_idx][u_hit_way];
      wr_cut    = ent_cut[u_idx][u_hit_way];
      wr_type   = ent_type[u_idx][u_hit_way];
      wr_conf   = cur_conf;
      vic_inc   = 1'b0;
      vic_nxt   = (victim[u_idx] == LAST_WAY) ? '0 : victim[u_idx] + WAY_W'(1);
      if (bus.update_valid && !bus.flush) begin
         if (u_hit) begin
            wr_en = 1'b1;
            if (bus.update_taken) begin
               wr_valid  = 1'b1;
               wr_conf   = (cur_conf == '1) ? cur_conf : cur_conf + CONF_W'(1);
               wr_target = bus.update_target;
               wr_cut    = bus.update_cut_pos;
               wr_type   = bus.update_branch_type;
            end else begin
               wr_conf  = cur_conf - CONF_W'(1);
               wr_valid = (wr_conf != '0);
            end
         end else if (bus.update_taken) begin
            wr_en     = 1'b1;
            wr_valid  = 1'b1;
            wr_conf   = CONF_INIT;
            wr_target = bus.update_target;
            wr_cut    = bus.update_cut_pos;
            wr_type   = bus.update_branch_type;
            if (u_free) begin
               wr_way = u_free_way;
            end else begin
               wr_way  = victim[u_idx];
               vic_inc = 1'b1;
            end
         end
      end
   end

   // lookup view of the indexed set with this cycle's write folded in
   logic              lk_valid  [WAYS];
   logic [TAG_W-1:0]  lk_tag    [WAYS];
   logic [31:0]       lk_target [WAYS];
   logic [1:0]        lk_cut    [WAYS];
   logic [1:0]        lk_type   [WAYS];
   logic [CONF_W-1:0] lk_conf   [WAYS];
   logic              byp;

   // Write-first bypass: the way being written this cycle is replaced by the
   // write record so the lookup sees allocation, eviction and invalidation.
   always_comb begin
      byp = wr_en && (u_idx == l_idx);
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (byp && (wr_way == WAY_W'(w))) begin
            lk_valid[w]  = wr_valid;
            lk_tag[w]    = wr_tag;
            lk_target[w] = wr_target;
            lk_cut[w]    = wr_cut;
            lk_type[w]   = wr_type;
            lk_conf[w]   = wr_conf;
         end else begin
            lk_valid[w]  = ent_valid[l_idx][w];
            lk_tag[w]    = ent_tag[l_idx][w];
            lk_target[w] = ent_target[l_idx][w];
            lk_cut[w]    = ent_cut[l_idx][w];
            lk_type[w]   = ent_type[l_idx][w];
            lk_conf[w]   = ent_conf[l_idx][w];
         end
      end
   end

   logic              l_hit, l_taken;
   logic [31:0]       l_target, pc_inc;
   logic [1:0]        l_cut, l_type;
   logic [CONF_W-1:0] l_conf;

   // Lowest matching way wins; a flush in the same cycle forces a miss.
   always_comb begin
      l_hit    = 1'b0;
      l_target = '0;
      l_cut    = '0;
      l_type   = BRANCH_TYPE_DIRECT;
      l_conf   = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!l_hit && lk_valid[w] && (lk_tag[w] == l_tag)) begin
            l_hit    = 1'b1;
            l_target = lk_target[w];
            l_cut    = lk_cut[w];
            l_type   = lk_type[w];
            l_conf   = lk_conf[w];
         end
      end
      if (bus.flush) begin
         l_hit = 1'b0;
      end
      l_taken = l_hit && l_conf[CONF_W-1];
      pc_inc  = bus.pred_pc + 32'd4;
   end

   // Valid bits, confidence and victim pointers; flush clears valid and victims.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s < SETS; s++) begin
            victim[s] <= '0;
            for (int unsigned w = 0; w < WAYS; w++) begin
               ent_valid[s][w] <= 1'b0;
               ent_conf[s][w]  <= '0;
            end
         end
      end else if (bus.flush) begin
         for (int unsigned s = 0; s < SETS; s++) begin
            victim[s] <= '0;
            for (int unsigned w = 0; w < WAYS; w++) begin
               ent_valid[s][w] <= 1'b0;
            end
         end
      end else if (wr_en) begin
         ent_valid[u_idx][wr_way] <= wr_valid;
         ent_conf[u_idx][wr_way]  <= wr_conf;
         if (vic_inc) begin
            victim[u_idx] <= vic_nxt;
         end
      end
   end

   // Entry payload; meaningless while the valid bit is clear, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         ent_tag[u_idx][wr_way]    <= wr_tag;
         ent_target[u_idx][wr_way] <= wr_target;
         ent_cut[u_idx][wr_way]    <= wr_cut;
         ent_type[u_idx][wr_way]   <= wr_type;
      end
   end

   // Registered prediction; payload outputs hold when no lookup was issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.pred_valid       <= 1'b0;
         bus.pred_hit         <= 1'b0;
         bus.pred_taken       <= 1'b0;
         bus.pred_next_pc     <= '0;
         bus.pred_cut_pos     <= '0;
         bus.pred_branch_type <= BRANCH_TYPE_DIRECT;
      end else begin
         bus.pred_valid <= bus.pred_req;
         if (bus.pred_req) begin
            bus.pred_hit         <= l_hit;
            bus.pred_taken       <= l_taken;
            bus.pred_next_pc     <= l_taken ? l_target : pc_inc;
            bus.pred_cut_pos     <= l_hit ? l_cut : 2'd0;
            bus.pred_branch_type <= l_hit ? l_type : BRANCH_TYPE_DIRECT;
         end
      end
   end

endmodule
